issue_queue: RTL
================

Name: issue_queue

Overview:
- Unified out-of-order issue queue directly downstream of rename.
- Accepts up to 4 renamed uops per cycle, each carrying ROB-tag source operands.
- Tracks operand readiness through writeback tag broadcasts and issues the oldest ready entry, one per cycle, to a single execute port.
- Dispatch is all-or-nothing per group, matching rename's atomic group handshake.

Parameters:
- IQ_DEPTH, 16, number of entries (power of two, >= 4).
- ROB_DEPTH, 64, ROB entries.
- ROB_IDX_WIDTH, $clog2(ROB_DEPTH), tag width.
- PAYLOAD_W, 64, opaque uop payload bits (fu, opcode, imm, arch reg ids) carried through unmodified.
- WB_PORTS, 2, number of writeback broadcast ports.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- flush_i  in  1  invalidate all entries.
- disp_valid_i  in  4  per-slot dispatch valid from rename.
- disp_rs1_in_rob_i  in  4  rs1 waits on a ROB tag.
- disp_rs1_rob_idx_i  in  4xROB_IDX_WIDTH  rs1 tag.
- disp_rs2_in_rob_i  in  4  rs2 waits on a ROB tag.
- disp_rs2_rob_idx_i  in  4xROB_IDX_WIDTH  rs2 tag.
- disp_rd_rob_idx_i  in  4xROB_IDX_WIDTH  destination tag.
- disp_payload_i  in  4xPAYLOAD_W  opaque payload.
- iq_ready_o  out  1  free entries >= 4.
- wb_valid_i  in  WB_PORTS  writeback broadcast valid.
- wb_rob_idx_i  in  WB_PORTSxROB_IDX_WIDTH  broadcast tag.
- issue_valid_o  out  1  an entry is selected.
- issue_ready_i  in  1  execute port accepts.
- issue_rd_rob_idx_o  out  ROB_IDX_WIDTH  selected destination tag.
- issue_rs1_rob_idx_o  out  ROB_IDX_WIDTH  selected rs1 tag.
- issue_rs2_rob_idx_o  out  ROB_IDX_WIDTH  selected rs2 tag.
- issue_payload_o  out  PAYLOAD_W  selected payload.
- free_cnt_o  out  $clog2(IQ_DEPTH)+1  current free entries.

Behaviour:
- Reset (rst_i high at a clock edge): all entries invalid, age matrix cleared, free_cnt_o = IQ_DEPTH, iq_ready_o = 1, issue_valid_o = 0, all issue data outputs 0.
- Entry state: valid, rs1_rdy, rs2_rdy, tags, payload. An operand is ready when its in_rob bit was 0 at dispatch or a matching tag was broadcast.
- Dispatch handshake:
  - A group is accepted only when iq_ready_o = 1. Valid slots with disp_valid_i set to 1 while iq_ready_o = 0 is a protocol error; the bench asserts it never happens.
  - Valid slots are written in slot order into the lowest-indexed free entries (priority encoder).
  - Slots with valid = 0 consume nothing.
- Age tracking: age matrix, where age[i][j] = 1 means entry i is older than j.
  - Slot k of a group is older than slot k+1.
  - A newly written entry is younger than every existing valid entry.
- Wakeup: each cycle, every valid entry compares both waiting tags against all valid wb ports and sets the matching rdy bit.
- Dispatch-cycle bypass: a disp tag equal to a same-cycle wb tag is written already ready. Without this, a uop could deadlock.
- Select (combinational from registered state):
  - issue_valid_o = 1 when any valid entry has both rdy bits set.
  - Outputs come from the oldest such entry.
  - A broadcast in cycle N makes the entry selectable in N+1; no same-cycle wakeup-to-issue.
  - Dispatch-to-issue minimum latency is 1 cycle.
- Issue handshake:
  - The entry is freed at the edge where issue_valid_o && issue_ready_i.
  - While issue_ready_i = 0, selection may change if an older entry becomes ready; outputs need not be stable.
- Free count: free_cnt_next = free_cnt + issued - dispatched_count.
  - iq_ready_o is registered-state based, i.e. (free_cnt_o >= 4).
  - An entry freed in cycle N counts toward free_cnt_o from N+1.
- Flush: takes priority over dispatch, issue and wakeup in the same cycle.
  - All entries are invalid next cycle and free_cnt_o = IQ_DEPTH.
  - issue_valid_o is forced to 0 during the flush cycle.
- Full boundary: with free_cnt_o = 4 and a 4-uop dispatch, free_cnt_o = 0 and iq_ready_o = 0 next cycle. A simultaneous issue makes free_cnt_o = 1, still not ready.
- Empty boundary: issue_valid_o = 0, outputs 0.
- Tags compare on full ROB_IDX_WIDTH. Tag wrap-around needs no special handling because the ROB guarantees uniqueness of live tags.

Optional Feature:
- Macro: IQ_PERF_CNT_EN.
- When defined, three 32-bit output ports are added:
  - perf_full_stall_o: cycles with iq_ready_o = 0 and any disp_valid_i set.
  - perf_issue_cnt_o: issue handshakes.
  - perf_empty_cnt_o: cycles with zero valid entries.
- Counters reset to 0 on rst_i, are not cleared by flush_i, and wrap at 2^32.
- When not defined, the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then dispatch 4 uops with all in_rob = 0 and rd tags 5,6,7,8, issue_ready_i = 1 → issue_valid_o on 4 consecutive cycles starting 1 cycle after dispatch, tags 5,6,7,8 in order; free_cnt_o returns to 16.
- Dispatch A (rd 10, rs1 waits tag 3), then B (rd 11, ready); broadcast tag 3 two cycles later → B issues first; A issues the cycle after the broadcast.
- Dispatch uop waiting on tag 20 in the same cycle wb_rob_idx_i[1] = 20 → entry captured ready; issues next cycle.
- Fill 16 entries all waiting on tag 40 → iq_ready_o = 0, free_cnt_o = 0. Broadcast 40 → 16 issues in dispatch order; iq_ready_o = 1 once free_cnt_o reaches 4.
- 8 valid entries, flush_i together with disp_valid_i = 4'b1111 and wb broadcast → next cycle free_cnt_o = 16, issue_valid_o = 0, dispatched group discarded.
- issue_ready_i held 0 for 5 cycles with 2 ready entries → no entry freed, free_cnt_o unchanged; on release, the oldest issues first.

Source files
------------

// File: rtl/issue_queue.sv
// Unified out-of-order issue queue: 4-wide atomic dispatch, tag wakeup with dispatch bypass,
// age-matrix oldest-ready select to one execute port. Define IQ_PERF_CNT_EN for perf counters.
module issue_queue #(
    parameter int IQ_DEPTH      = 16,
    parameter int ROB_DEPTH     = 64,
    parameter int ROB_IDX_WIDTH = $clog2(ROB_DEPTH),
    parameter int PAYLOAD_W     = 64,
    parameter int WB_PORTS      = 2
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                flush_i,
    input  logic [3:0]                          disp_valid_i,
    input  logic [3:0]                          disp_rs1_in_rob_i,
    input  logic [3:0][ROB_IDX_WIDTH-1:0]       disp_rs1_rob_idx_i,
    input  logic [3:0]                          disp_rs2_in_rob_i,
    input  logic [3:0][ROB_IDX_WIDTH-1:0]       disp_rs2_rob_idx_i,
    input  logic [3:0][ROB_IDX_WIDTH-1:0]       disp_rd_rob_idx_i,
    input  logic [3:0][PAYLOAD_W-1:0]           disp_payload_i,
    output logic                                iq_ready_o,
    input  logic [WB_PORTS-1:0]                 wb_valid_i,
    input  logic [WB_PORTS-1:0][ROB_IDX_WIDTH-1:0] wb_rob_idx_i,
    output logic                                issue_valid_o,
    input  logic                                issue_ready_i,
    output logic [ROB_IDX_WIDTH-1:0]            issue_rd_rob_idx_o,
    output logic [ROB_IDX_WIDTH-1:0]            issue_rs1_rob_idx_o,
    output logic [ROB_IDX_WIDTH-1:0]            issue_rs2_rob_idx_o,
    output logic [PAYLOAD_W-1:0]                issue_payload_o,
    output logic [$clog2(IQ_DEPTH):0]           free_cnt_o
`ifdef IQ_PERF_CNT_EN
    ,
    output logic [31:0]                         perf_full_stall_o,
    output logic [31:0]                         perf_issue_cnt_o,
    output logic [31:0]                         perf_empty_cnt_o
`endif
);

    localparam int FREE_W = $clog2(IQ_DEPTH) + 1;

    logic [IQ_DEPTH-1:0]                     valid_reg;
    logic [IQ_DEPTH-1:0]                     rs1_rdy_reg;
    logic [IQ_DEPTH-1:0]                     rs2_rdy_reg;
    logic [IQ_DEPTH-1:0][ROB_IDX_WIDTH-1:0]  rs1_tag_reg;
    logic [IQ_DEPTH-1:0][ROB_IDX_WIDTH-1:0]  rs2_tag_reg;
    logic [IQ_DEPTH-1:0][ROB_IDX_WIDTH-1:0]  rd_tag_reg;
    logic [IQ_DEPTH-1:0][PAYLOAD_W-1:0]      payload_reg;
    logic [IQ_DEPTH-1:0][IQ_DEPTH-1:0]       age_reg;
    logic [FREE_W-1:0]                       free_cnt_reg;
    logic [FREE_W-1:0]                       free_cnt_next;

    logic [3:0]                              disp_fire;
    logic [FREE_W-1:0]                       disp_cnt;
    logic [3:0]                              byp1;
    logic [3:0]                              byp2;
    logic [3:0][IQ_DEPTH-1:0]                alloc_oh;
    logic [3:0][IQ_DEPTH-1:0]                earlier_mask;
    logic [IQ_DEPTH-1:0]                     taken_mask;
    logic [IQ_DEPTH-1:0]                     new_mask;
    logic [IQ_DEPTH-1:0][1:0]                wr_slot;
    logic [IQ_DEPTH-1:0][IQ_DEPTH-1:0]       age_row_new;
    logic [IQ_DEPTH-1:0]                     wake1;
    logic [IQ_DEPTH-1:0]                     wake2;
    logic [IQ_DEPTH-1:0]                     ready;
    logic [IQ_DEPTH-1:0]                     grant;
    logic                                    issue_fire;

    function automatic logic tag_hit(
        input logic [ROB_IDX_WIDTH-1:0]                tag,
        input logic [WB_PORTS-1:0]                     wv,
        input logic [WB_PORTS-1:0][ROB_IDX_WIDTH-1:0]  wt
    );
        logic hit;
        hit = 1'b0;
        for (int p = 0; p < WB_PORTS; p++) begin
            hit = hit | (wv[p] && (wt[p] == tag));
        end
        return hit;
    endfunction

    assign iq_ready_o = (free_cnt_reg >= FREE_W'(4));
    assign free_cnt_o = free_cnt_reg;
    assign disp_fire  = disp_valid_i & {4{iq_ready_o & ~flush_i}};
    assign disp_cnt   = FREE_W'(disp_fire[0]) + FREE_W'(disp_fire[1])
                      + FREE_W'(disp_fire[2]) + FREE_W'(disp_fire[3]);

    // Slots claim the lowest free entries in slot order; earlier_mask records what
    // preceding slots of the same group took, which orders them older in the age matrix.
    always_comb begin
        taken_mask   = '0;
        alloc_oh     = '0;
        earlier_mask = '0;
        for (int k = 0; k < 4; k++) begin
            earlier_mask[k] = taken_mask;
            if (disp_fire[k]) begin
                for (int i = 0; i < IQ_DEPTH; i++) begin
                    if (!valid_reg[i] && !taken_mask[i] && (alloc_oh[k] == '0)) begin
                        alloc_oh[k][i] = 1'b1;
                    end
                end
            end
            taken_mask = taken_mask | alloc_oh[k];
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_slot
            assign byp1[gi] = tag_hit(disp_rs1_rob_idx_i[gi], wb_valid_i, wb_rob_idx_i);
            assign byp2[gi] = tag_hit(disp_rs2_rob_idx_i[gi], wb_valid_i, wb_rob_idx_i);
        end

        for (genvar gi = 0; gi < IQ_DEPTH; gi++) begin : g_entry
            logic [IQ_DEPTH-1:0] older_rdy;

            assign new_mask[gi] = alloc_oh[0][gi] | alloc_oh[1][gi] | alloc_oh[2][gi] | alloc_oh[3][gi];
            assign wr_slot[gi]  = {alloc_oh[3][gi] | alloc_oh[2][gi], alloc_oh[3][gi] | alloc_oh[1][gi]};
            assign wake1[gi]    = tag_hit(rs1_tag_reg[gi], wb_valid_i, wb_rob_idx_i);
            assign wake2[gi]    = tag_hit(rs2_tag_reg[gi], wb_valid_i, wb_rob_idx_i);
            assign ready[gi]    = valid_reg[gi] & rs1_rdy_reg[gi] & rs2_rdy_reg[gi];
            // A new entry is younger than every live entry and every earlier slot of its group.
            assign age_row_new[gi] = ~valid_reg & ~earlier_mask[wr_slot[gi]] & ~(IQ_DEPTH'(1) << gi);

            for (genvar gj = 0; gj < IQ_DEPTH; gj++) begin : g_older
                if (gj == gi) begin : g_self
                    assign older_rdy[gj] = 1'b0;
                end else begin : g_other
                    assign older_rdy[gj] = ready[gj] & age_reg[gj][gi];
                end
            end

            assign grant[gi] = ready[gi] & ~(|older_rdy);
        end
    endgenerate

    assign issue_valid_o = (|grant) & ~flush_i;
    assign issue_fire    = issue_valid_o & issue_ready_i;
    assign free_cnt_next = free_cnt_reg + FREE_W'(issue_fire) - disp_cnt;

    always_comb begin
        issue_rd_rob_idx_o  = '0;
        issue_rs1_rob_idx_o = '0;
        issue_rs2_rob_idx_o = '0;
        issue_payload_o     = '0;
        for (int i = 0; i < IQ_DEPTH; i++) begin
            if (grant[i] && !flush_i) begin
                issue_rd_rob_idx_o  = issue_rd_rob_idx_o  | rd_tag_reg[i];
                issue_rs1_rob_idx_o = issue_rs1_rob_idx_o | rs1_tag_reg[i];
                issue_rs2_rob_idx_o = issue_rs2_rob_idx_o | rs2_tag_reg[i];
                issue_payload_o     = issue_payload_o     | payload_reg[i];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_reg    <= '0;
            rs1_rdy_reg  <= '0;
            rs2_rdy_reg  <= '0;
            age_reg      <= '0;
            free_cnt_reg <= FREE_W'(IQ_DEPTH);
        end else if (flush_i) begin
            valid_reg    <= '0;
            free_cnt_reg <= FREE_W'(IQ_DEPTH);
        end else begin
            for (int i = 0; i < IQ_DEPTH; i++) begin
                if (new_mask[i]) begin
                    valid_reg[i]   <= 1'b1;
                    rs1_rdy_reg[i] <= ~disp_rs1_in_rob_i[wr_slot[i]] | byp1[wr_slot[i]];
                    rs2_rdy_reg[i] <= ~disp_rs2_in_rob_i[wr_slot[i]] | byp2[wr_slot[i]];
                    rs1_tag_reg[i] <= disp_rs1_rob_idx_i[wr_slot[i]];
                    rs2_tag_reg[i] <= disp_rs2_rob_idx_i[wr_slot[i]];
                    rd_tag_reg[i]  <= disp_rd_rob_idx_i[wr_slot[i]];
                    payload_reg[i] <= disp_payload_i[wr_slot[i]];
                    age_reg[i]     <= age_row_new[i];
                end else begin
                    if (issue_fire && grant[i]) begin
                        valid_reg[i] <= 1'b0;
                    end
                    if (wake1[i]) begin
                        rs1_rdy_reg[i] <= 1'b1;
                    end
                    if (wake2[i]) begin
                        rs2_rdy_reg[i] <= 1'b1;
                    end
                    age_reg[i] <= age_reg[i] | (new_mask & {IQ_DEPTH{valid_reg[i]}});
                end
            end
            free_cnt_reg <= free_cnt_next;
        end
    end

`ifdef IQ_PERF_CNT_EN
    logic [31:0] perf_full_stall_reg;
    logic [31:0] perf_issue_cnt_reg;
    logic [31:0] perf_empty_cnt_reg;

    // Counters survive flush; only reset clears them.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_full_stall_reg <= '0;
            perf_issue_cnt_reg  <= '0;
            perf_empty_cnt_reg  <= '0;
        end else begin
            if (!iq_ready_o && (|disp_valid_i)) begin
                perf_full_stall_reg <= perf_full_stall_reg + 32'd1;
            end
            if (issue_fire) begin
                perf_issue_cnt_reg <= perf_issue_cnt_reg + 32'd1;
            end
            if (valid_reg == '0) begin
                perf_empty_cnt_reg <= perf_empty_cnt_reg + 32'd1;
            end
        end
    end

    assign perf_full_stall_o = perf_full_stall_reg;
    assign perf_issue_cnt_o  = perf_issue_cnt_reg;
    assign perf_empty_cnt_o  = perf_empty_cnt_reg;
`endif

endmodule
